// File: rtl/btn_pkg.sv
// Shared constants for the push-button conditioning block: channel indices,
// default channel count and the per-channel debounce state encoding.
package btn_pkg;

  localparam int NUM_BTN_DEFAULT = 4;

  localparam int BTN_U = 0;
  localparam int BTN_R = 1;
  localparam int BTN_D = 2;
  localparam int BTN_L = 3;

  localparam logic [1:0] IDLE            = 2'd0;
  localparam logic [1:0] CONFIRM_PRESS   = 2'd1;
  localparam logic [1:0] HELD            = 2'd2;
  localparam logic [1:0] CONFIRM_RELEASE = 2'd3;

endpackage

// File: rtl/btn_debounce_chan.sv
// One button channel: two-flop synchroniser, stability FSM and counter.
// Auto-repeat of press pulses while held is enabled by BTN_AUTOREPEAT_EN.
module btn_debounce_chan
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean,
  output logic press,
  output logic release_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the confirm states must accept on entry.
  localparam logic [CNT_W-1:0] CNT_FIRST = (DEBOUNCE_CYCLES > 1) ? CNT_W'(1) : '0;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_FIRE   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);
  logic [REP_W-1:0] rep_cnt;
`endif

  logic [1:0]       sync_ff;
  logic             sync;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  assign sync = sync_ff[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[0], raw};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      clean         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt       <= '0;
`endif
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= CONFIRM_PRESS;
            cnt   <= CNT_FIRST;
          end
        end
        CONFIRM_PRESS: begin
          if (!sync) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            cnt   <= '0;
            clean <= 1'b1;
            press <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync) begin
            state <= CONFIRM_RELEASE;
            cnt   <= CNT_FIRST;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == REP_FIRE) begin
            // Reload so the next pulse lands REPEAT_RATE cycles later.
            press   <= 1'b1;
            rep_cnt <= REP_RELOAD;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
`endif
          end
        end
        CONFIRM_RELEASE: begin
          if (sync) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            clean         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces the four board push-buttons (bit 0=U, 1=R, 2=D, 3=L) into clean
// levels plus press/release pulses; BTN_AUTOREPEAT_EN adds held-key repeat.
module button_debouncer
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = NUM_BTN_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  // Channels are fully independent; any priority is resolved downstream.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE (REPEAT_RATE)
`endif
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .raw          (btn_raw[i]),
      .clean        (btn_clean[i]),
      .press        (btn_press[i]),
      .release_pulse(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: stimulus queues the expected pulse
// events, a negedge monitor pops and compares whenever any pulse appears.
module tb_button_debouncer;

  localparam int DEB = 8;
  localparam int LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_clean;
  logic [3:0] btn_press;
  logic [3:0] btn_release;

  button_debouncer #(
    .NUM_BTN(4),
    .DEBOUNCE_CYCLES(DEB)
`ifdef BTN_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY(20),
    .REPEAT_RATE(5)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .btn_clean(btn_clean),
    .btn_press(btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] clean;
  } ev_t;

  ev_t exp_q[$];
  int  tests_run = 0;
  int  tests_failed = 0;

  task automatic expect_event(input int at, input logic [3:0] p, input logic [3:0] r,
                              input logic [3:0] c);
    ev_t e;
    e.at = at;
    e.press = p;
    e.rel = r;
    e.clean = c;
    exp_q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_vec(input string name, input logic [3:0] act, input logic [3:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Any pulse on any channel is an output event that must match the queue head.
  always @(negedge clk) begin
    if ((btn_press !== 4'b0000) || (btn_release !== 4'b0000)) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_event: cyc %0d press=%b release=%b clean=%b",
                 cyc, btn_press, btn_release, btn_clean);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.at != cyc || btn_press !== e.press || btn_release !== e.rel ||
            btn_clean !== e.clean) begin
          tests_failed++;
          $display("[TB] FAIL event: got cyc %0d press=%b release=%b clean=%b, expected cyc %0d press=%b release=%b clean=%b",
                   cyc, btn_press, btn_release, btn_clean, e.at, e.press, e.rel, e.clean);
        end
      end
    end
  end

  initial begin
    int c;
    reset = 1'b1;
    btn_raw = 4'b0000;
    wait_cycles(3);
    check_vec("reset_clean", btn_clean, 4'b0000);
    check_vec("reset_press", btn_press, 4'b0000);
    check_vec("reset_release", btn_release, 4'b0000);
    reset = 1'b0;
    wait_cycles(3);
    check_vec("idle_clean", btn_clean, 4'b0000);

    // U: clean rise and one press pulse after 2 sync + DEB cycles
    btn_raw[0] = 1'b1; c = cyc;
    expect_event(c + LAT, 4'b0001, 4'b0000, 4'b0001);
    wait_cycles(LAT - 1);
    check_vec("u_before_accept", btn_clean, 4'b0000);
    wait_cycles(5);
    check_vec("u_held_clean", btn_clean, 4'b0001);

    // R: 3-cycle bounce phases are rejected, final rise accepted
    btn_raw[1] = 1'b1; wait_cycles(3);
    btn_raw[1] = 1'b0; wait_cycles(3);
    btn_raw[1] = 1'b1; wait_cycles(3);
    btn_raw[1] = 1'b0; wait_cycles(3);
    check_vec("r_bounce_clean", btn_clean, 4'b0001);
    btn_raw[1] = 1'b1; c = cyc;
    expect_event(c + LAT, 4'b0010, 4'b0000, 4'b0011);
    wait_cycles(LAT + 4);

    // D: press, 5-cycle low glitch while held, then genuine release
    btn_raw[2] = 1'b1; c = cyc;
    expect_event(c + LAT, 4'b0100, 4'b0000, 4'b0111);
    wait_cycles(LAT + 4);
    btn_raw[2] = 1'b0; wait_cycles(5);
    btn_raw[2] = 1'b1; wait_cycles(15);
    check_vec("d_glitch_clean", btn_clean, 4'b0111);
    btn_raw[2] = 1'b0; c = cyc;
    expect_event(c + LAT, 4'b0000, 4'b0100, 4'b0011);
    wait_cycles(LAT + 4);

    // U and R released together
    btn_raw = 4'b0000; c = cyc;
    expect_event(c + LAT, 4'b0000, 4'b0011, 4'b0000);
    wait_cycles(LAT + 4);

    // All four pressed and released in the same cycle
    btn_raw = 4'b1111; c = cyc;
    expect_event(c + LAT, 4'b1111, 4'b0000, 4'b1111);
    wait_cycles(LAT + 4);
    btn_raw = 4'b0000; c = cyc;
    expect_event(c + LAT, 4'b0000, 4'b1111, 4'b0000);
    wait_cycles(LAT + 4);

    // Reset mid-confirm discards the count; held button requalifies afterwards
    btn_raw = 4'b0001;
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(1);
    check_vec("midreset_clean", btn_clean, 4'b0000);
    check_vec("midreset_press", btn_press, 4'b0000);
    wait_cycles(1);
    reset = 1'b0; c = cyc;
    expect_event(c + LAT, 4'b0001, 4'b0000, 4'b0001);
    wait_cycles(LAT - 1);
    check_vec("requal_before", btn_clean, 4'b0000);
    wait_cycles(5);
    btn_raw = 4'b0000; c = cyc;
    expect_event(c + LAT, 4'b0000, 4'b0001, 4'b0000);
    wait_cycles(LAT + 4);

`ifdef BTN_AUTOREPEAT_EN
    // L held: repeats at 20, 25, 30 cycles after the accepted press
    btn_raw = 4'b1000; c = cyc;
    expect_event(c + LAT,      4'b1000, 4'b0000, 4'b1000);
    expect_event(c + LAT + 20, 4'b1000, 4'b0000, 4'b1000);
    expect_event(c + LAT + 25, 4'b1000, 4'b0000, 4'b1000);
    expect_event(c + LAT + 30, 4'b1000, 4'b0000, 4'b1000);
    wait_cycles(LAT + 31);
    btn_raw = 4'b0000; c = cyc;
    expect_event(c + LAT, 4'b0000, 4'b1000, 4'b0000);
    wait_cycles(LAT + 10);
`endif

    wait_cycles(2);
    check_vec("final_clean", btn_clean, 4'b0000);
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL missing_events: %0d still queued, expected 0 (next due cyc %0d)",
               exp_q.size(), exp_q[0].at);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
